// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - shared constants, sprite ids and renderer states for the board renderer
// Ports: none (package).
package board_pkg;

  localparam int TILE_PX  = 8;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef enum logic [2:0] {
    FLOOR          = 3'd0,
    WALL           = 3'd1,
    BOX            = 3'd2,
    GOAL           = 3'd3,
    BOX_ON_GOAL    = 3'd4,
    PLAYER         = 3'd5,
    PLAYER_ON_GOAL = 3'd6,
    EMPTY          = 3'd7
  } sprite_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_DATA,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_ADVANCE,
    ST_FINISH
  } render_state_e;

  // Linear board RAM address of a tile.
  function automatic int tile_addr(input int col, input int row, input int cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/board_renderer_if.sv
// rtl/board_renderer_if.sv - control, board RAM and sprite drawer signals of the board renderer
// Signals: start/busy/frame_done (control), map_addr/map_data (board RAM),
//          draw_x/draw_y/draw_sprite_id/draw_go/draw_done (sprite drawer),
//          tile_req/tile_col/tile_row/tile_ready only when RENDER_TILE_UPDATE_EN is defined.
// Modports: master = renderer side, slave = environment side.
interface board_renderer_if #(
  parameter int AW = 8
);
  logic          start;
  logic          busy;
  logic          frame_done;
  logic [AW-1:0] map_addr;
  logic [2:0]    map_data;
  logic [7:0]    draw_x;
  logic [6:0]    draw_y;
  logic [2:0]    draw_sprite_id;
  logic          draw_go;
  logic          draw_done;
`ifdef RENDER_TILE_UPDATE_EN
  logic          tile_req;
  logic [4:0]    tile_col;
  logic [3:0]    tile_row;
  logic          tile_ready;
`endif

  modport master (
`ifdef RENDER_TILE_UPDATE_EN
    input  tile_req, tile_col, tile_row,
    output tile_ready,
`endif
    input  start, map_data, draw_done,
    output busy, frame_done, map_addr, draw_x, draw_y, draw_sprite_id, draw_go
  );

  modport slave (
`ifdef RENDER_TILE_UPDATE_EN
    output tile_req, tile_col, tile_row,
    input  tile_ready,
`endif
    output start, map_data, draw_done,
    input  busy, frame_done, map_addr, draw_x, draw_y, draw_sprite_id, draw_go
  );

endinterface

// File: rtl/board_scan_counter.sv
// rtl/board_scan_counter.sv - raster col/row tile counter with wrap and last-tile flag
// Ports: clk, reset (sync, active-high); clear -> (0,0); load -> (load_col,load_row);
//        advance -> next tile in raster order; col/row current position;
//        col_nxt/row_nxt position after this cycle; last = current tile is the final one.
module board_scan_counter
  import board_pkg::*;
#(
  parameter int COLS = 16,
  parameter int ROWS = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic [4:0] load_col,
  input  logic [3:0] load_row,
  input  logic       advance,
  output logic [4:0] col,
  output logic [3:0] row,
  output logic [4:0] col_nxt,
  output logic [3:0] row_nxt,
  output logic       last
);

  logic [4:0] col_q, col_d;
  logic [3:0] row_q, row_d;
  logic       col_end;

  assign col_end = (col_q == 5'(COLS - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (load) begin
      col_d = load_col;
      row_d = load_row;
    end else if (advance) begin
      if (col_end) begin
        col_d = '0;
        row_d = (row_q == 4'(ROWS - 1)) ? '0 : row_q + 4'd1;
      end else begin
        col_d = col_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col     = col_q;
  assign row     = row_q;
  assign col_nxt = col_d;
  assign row_nxt = row_d;
  assign last    = col_end && (row_q == 4'(ROWS - 1));

endmodule

// File: rtl/board_renderer.sv
// rtl/board_renderer.sv - walks the Sokoban tile map and issues one 8x8 sprite draw per tile
// Ports: clk, reset (sync, active-high); bus (board_renderer_if.master): start/busy/frame_done,
//        map_addr/map_data board RAM read (1-cycle latency), draw_* sprite drawer handshake.
// Optional single-tile redraw (tile_req/tile_col/tile_row/tile_ready) under RENDER_TILE_UPDATE_EN.
module board_renderer
  import board_pkg::*;
#(
  parameter int COLS     = 16,
  parameter int ROWS     = 12,
  parameter int X_ORIGIN = 16,
  parameter int Y_ORIGIN = 12,
  parameter int AW       = (COLS * ROWS > 1) ? $clog2(COLS * ROWS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  board_renderer_if.master  bus
);

  render_state_e state_q, state_d;
  logic [AW-1:0] map_addr_q, map_addr_d;
  logic [7:0]    draw_x_q, draw_x_d;
  logic [6:0]    draw_y_q, draw_y_d;
  sprite_e       sprite_q, sprite_d;

  logic          cnt_clear, cnt_load, cnt_advance, cnt_last;
  logic [4:0]    col, col_nxt, load_col;
  logic [3:0]    row, row_nxt, load_row;

`ifdef RENDER_TILE_UPDATE_EN
  logic          single_q, single_d;
  logic          tile_in_range;

  assign tile_in_range  = (int'(bus.tile_col) < COLS) && (int'(bus.tile_row) < ROWS);
  assign load_col       = bus.tile_col;
  assign load_row       = bus.tile_row;
  // start has priority, so a tile request is never accepted in the same cycle as start.
  assign bus.tile_ready = (state_q == ST_IDLE) && !bus.start;
`else
  assign load_col = '0;
  assign load_row = '0;
`endif

  board_scan_counter #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) u_scan (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .load    (cnt_load),
    .load_col(load_col),
    .load_row(load_row),
    .advance (cnt_advance),
    .col     (col),
    .row     (row),
    .col_nxt (col_nxt),
    .row_nxt (row_nxt),
    .last    (cnt_last)
  );

  always_comb begin
    state_d     = state_q;
    draw_x_d    = draw_x_q;
    draw_y_d    = draw_y_q;
    sprite_d    = sprite_q;
    cnt_clear   = 1'b0;
    cnt_load    = 1'b0;
    cnt_advance = 1'b0;
`ifdef RENDER_TILE_UPDATE_EN
    single_d    = single_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          cnt_clear = 1'b1;
          state_d   = ST_FETCH;
`ifdef RENDER_TILE_UPDATE_EN
          single_d  = 1'b0;
        end else if (bus.tile_req) begin
          cnt_load  = 1'b1;
          single_d  = 1'b1;
          state_d   = tile_in_range ? ST_FETCH : ST_FINISH;
`endif
        end
      end
      ST_FETCH:     state_d = ST_WAIT_DATA;
      ST_WAIT_DATA: begin
        sprite_d = sprite_e'(bus.map_data);
        draw_x_d = 8'(X_ORIGIN + int'(col) * TILE_PX);
        draw_y_d = 7'(Y_ORIGIN + int'(row) * TILE_PX);
        state_d  = ST_ISSUE;
      end
      ST_ISSUE:     state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (bus.draw_done) begin
`ifdef RENDER_TILE_UPDATE_EN
          state_d = single_q ? ST_FINISH : ST_ADVANCE;
`else
          state_d = ST_ADVANCE;
`endif
        end
      end
      ST_ADVANCE: begin
        cnt_advance = 1'b1;
        state_d     = cnt_last ? ST_FINISH : ST_FETCH;
      end
      ST_FINISH:    state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // The address is registered on entry to FETCH so RAM data is valid during WAIT_DATA.
  always_comb begin
    map_addr_d = map_addr_q;
    if (state_d == ST_FETCH) begin
      map_addr_d = AW'(tile_addr(int'(col_nxt), int'(row_nxt), COLS));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      map_addr_q <= '0;
      draw_x_q   <= 8'(X_ORIGIN);
      draw_y_q   <= 7'(Y_ORIGIN);
      sprite_q   <= FLOOR;
`ifdef RENDER_TILE_UPDATE_EN
      single_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      map_addr_q <= map_addr_d;
      draw_x_q   <= draw_x_d;
      draw_y_q   <= draw_y_d;
      sprite_q   <= sprite_d;
`ifdef RENDER_TILE_UPDATE_EN
      single_q   <= single_d;
`endif
    end
  end

  assign bus.map_addr       = map_addr_q;
  assign bus.draw_x         = draw_x_q;
  assign bus.draw_y         = draw_y_q;
  assign bus.draw_sprite_id = sprite_q;
  assign bus.draw_go        = (state_q == ST_ISSUE);
  assign bus.frame_done     = (state_q == ST_FINISH);
  assign bus.busy           = (state_q != ST_IDLE) && (state_q != ST_FINISH);

endmodule

// File: tb/tb_board_renderer.sv
// tb/tb_board_renderer.sv - self-checking bench for board_renderer (4x3 board, random RAM and drawer latency)
module tb_board_renderer;
  import board_pkg::*;

  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam int XO   = 16;
  localparam int YO   = 12;
  localparam int AW   = 4;
  localparam int N    = COLS * ROWS;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  board_renderer_if #(.AW(AW)) bif ();

  board_renderer #(
    .COLS(COLS), .ROWS(ROWS), .X_ORIGIN(XO), .Y_ORIGIN(YO), .AW(AW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif)
  );

  // Board RAM: one-cycle read latency.
  logic [2:0] mem [2**AW];
  always @(posedge clk) bif.map_data <= mem[bif.map_addr];

  // Drawer: answers each draw_go with draw_done drawer_lat cycles later when enabled.
  int   drawer_lat = 3;
  bit   drawer_en  = 1'b1;
  int   dcnt       = 0;
  logic auto_done  = 1'b0;
  logic man_done   = 1'b0;
  always @(posedge clk) begin
    auto_done <= 1'b0;
    if (reset) dcnt <= 0;
    else if (bif.draw_go === 1'b1 && drawer_en) dcnt <= drawer_lat;
    else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) auto_done <= 1'b1;
    end
  end
  assign bif.draw_done = auto_done | man_done;

  function automatic logic [31:0] pk(input logic [7:0] x, input logic [6:0] y,
                                     input logic [2:0] id, input logic [AW-1:0] a);
    return {10'b0, x, y, id, a};
  endfunction

  // Reference: tile t sits at col t%COLS, row t/COLS, drawn with the RAM content at t.
  function automatic logic [31:0] exp_tile(input int t);
    int c, r;
    c = t % COLS;
    r = t / COLS;
    return pk(8'(XO + c * 8), 7'(YO + r * 8), mem[t], AW'(t));
  endfunction

  // Monitor: every draw_go with its anchor/id/address and FETCH-to-go latency.
  logic [31:0]   go_q[$];
  int            lat_q[$];
  int            fd_cnt = 0;
  int            cyc = 0, last_chg = 0;
  logic [AW-1:0] prev_addr = '0;
  always @(negedge clk) begin
    cyc++;
    if (bif.map_addr !== prev_addr) last_chg = cyc;
    prev_addr = bif.map_addr;
    if (bif.draw_go === 1'b1) begin
      go_q.push_back(pk(bif.draw_x, bif.draw_y, bif.draw_sprite_id, bif.map_addr));
      lat_q.push_back(cyc - last_chg);
    end
    if (bif.frame_done === 1'b1) fd_cnt++;
  end

  int n_pass = 0, n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic wait_frame(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (bif.frame_done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_go(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (bif.draw_go === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic check_frame(input string tag, input int base);
    int bad_lat;
    bad_lat = 0;
    chk({tag, "_count"}, 32'(go_q.size() - base), 32'(N));
    for (int t = 0; t < N && base + t < go_q.size(); t++) begin
      chk($sformatf("%s_tile%0d", tag, t), go_q[base + t], exp_tile(t));
      if (t > 0 && lat_q[base + t] != 2) bad_lat++;
    end
    chk({tag, "_latency"}, 32'(bad_lat), 32'd0);
  endtask

  task automatic run_frame(input string tag, input int extra_starts);
    int base, fdb;
    bit ok;
    base = go_q.size();
    fdb  = fd_cnt;
    bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    for (int k = 0; k < extra_starts; k++) begin
      repeat ($urandom_range(3, 12)) @(negedge clk);
      bif.start = 1'b1;
      @(negedge clk);
      bif.start = 1'b0;
    end
    wait_frame(3000, ok);
    chk({tag, "_frame_done"}, 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
    chk({tag, "_one_frame_done"}, 32'(fd_cnt - fdb), 32'd1);
    chk({tag, "_idle_busy"}, 32'(bif.busy), 32'd0);
    check_frame(tag, base);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  base, fdb, unstable, gos;
    bit  ok;
    logic [31:0] snap;

    reset     = 1'b1;
    bif.start = 1'b0;
`ifdef RENDER_TILE_UPDATE_EN
    bif.tile_req = 1'b0;
    bif.tile_col = '0;
    bif.tile_row = '0;
`endif
    for (int i = 0; i < 2**AW; i++) mem[i] = 3'(i % 8);

    repeat (3) @(negedge clk);
    chk("rst_busy",       32'(bif.busy),           32'd0);
    chk("rst_frame_done", 32'(bif.frame_done),     32'd0);
    chk("rst_draw_go",    32'(bif.draw_go),        32'd0);
    chk("rst_map_addr",   32'(bif.map_addr),       32'd0);
    chk("rst_draw_x",     32'(bif.draw_x),         32'(XO));
    chk("rst_draw_y",     32'(bif.draw_y),         32'(YO));
    chk("rst_sprite",     32'(bif.draw_sprite_id), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Full redraw with id = addr % 8, drawer latency 3.
    run_frame("f_mod8", 0);

    // Random boards, random drawer latency, start pulsed while busy.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 2**AW; i++) mem[i] = 3'($urandom);
      drawer_lat = $urandom_range(1, 6);
      run_frame($sformatf("f_rand%0d", f), f + 1);
    end

    // Spurious draw_done in IDLE.
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    @(negedge clk);
    chk("spur_idle_busy", 32'(bif.busy),    32'd0);
    chk("spur_idle_go",   32'(bif.draw_go), 32'd0);

    // Spurious draw_done in FETCH, then a 200-cycle drawer stall.
    drawer_en = 1'b0;
    base = go_q.size();
    bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    man_done  = 1'b1;
    chk("spur_fetch_busy", 32'(bif.busy), 32'd1);
    @(negedge clk);
    man_done = 1'b0;
    chk("spur_wait_data_go", 32'(bif.draw_go), 32'd0);
    @(negedge clk);
    chk("spur_issue_go", 32'(bif.draw_go), 32'd1);
    snap = pk(bif.draw_x, bif.draw_y, bif.draw_sprite_id, bif.map_addr);
    chk("spur_issue_tile0", snap, exp_tile(0));
    unstable = 0;
    gos      = 0;
    repeat (200) begin
      @(negedge clk);
      if (pk(bif.draw_x, bif.draw_y, bif.draw_sprite_id, bif.map_addr) !== snap) unstable++;
      if (bif.draw_go !== 1'b0) gos++;
      if (bif.busy !== 1'b1) unstable++;
    end
    chk("stall_stable", 32'(unstable), 32'd0);
    chk("stall_no_go",  32'(gos),      32'd0);
    drawer_en = 1'b1;
    man_done  = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    wait_frame(3000, ok);
    chk("stall_frame_done", 32'(ok), 32'd1);
    repeat (2) @(negedge clk);
    check_frame("stall", base);

    // Reset while waiting for the drawer on tile 5, then a clean redraw.
    for (int i = 0; i < 2**AW; i++) mem[i] = 3'($urandom);
    drawer_en = 1'b0;
    bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    for (int t = 0; t < 6; t++) begin
      wait_go(100, ok);
      chk($sformatf("rst_mid_go%0d", t), 32'(ok), 32'd1);
      if (t < 5) begin
        repeat (2) @(negedge clk);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
      end
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy",     32'(bif.busy),     32'd0);
    chk("rst_mid_go",       32'(bif.draw_go),  32'd0);
    chk("rst_mid_map_addr", 32'(bif.map_addr), 32'd0);
    reset    = 1'b0;
    man_done = 1'b1;
    base     = go_q.size();
    @(negedge clk);
    man_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_late_done_busy", 32'(bif.busy),                 32'd0);
    chk("rst_late_done_nogo", 32'(go_q.size() - base),       32'd0);
    drawer_en  = 1'b1;
    drawer_lat = 2;
    run_frame("after_rst", 0);

`ifdef RENDER_TILE_UPDATE_EN
    chk("tile_ready_idle", 32'(bif.tile_ready), 32'd1);
    bif.start = 1'b1;
    #1;
    chk("tile_ready_start", 32'(bif.tile_ready), 32'd0);
    bif.start = 1'b0;
    @(negedge clk);

    // Single in-range tile at (3,2).
    base = go_q.size();
    fdb  = fd_cnt;
    bif.tile_col = 5'd3;
    bif.tile_row = 4'd2;
    bif.tile_req = 1'b1;
    @(negedge clk);
    bif.tile_req = 1'b0;
    wait_frame(500, ok);
    chk("tile_frame_done", 32'(ok), 32'd1);
    repeat (2) @(negedge clk);
    chk("tile_count", 32'(go_q.size() - base), 32'd1);
    chk("tile_fd",    32'(fd_cnt - fdb),       32'd1);
    if (go_q.size() > base) chk("tile_draw", go_q[base], pk(8'd40, 7'd28, mem[11], AW'(11)));

    // start and tile_req together: full redraw only.
    base = go_q.size();
    bif.tile_col = 5'd1;
    bif.tile_row = 4'd0;
    bif.tile_req = 1'b1;
    bif.start    = 1'b1;
    @(negedge clk);
    bif.tile_req = 1'b0;
    bif.start    = 1'b0;
    wait_frame(3000, ok);
    chk("both_frame_done", 32'(ok), 32'd1);
    repeat (2) @(negedge clk);
    check_frame("both", base);

    // Out-of-range column: no draw, still a frame_done pulse.
    base = go_q.size();
    fdb  = fd_cnt;
    bif.tile_col = 5'd20;
    bif.tile_row = 4'd0;
    bif.tile_req = 1'b1;
    @(negedge clk);
    bif.tile_req = 1'b0;
    wait_frame(50, ok);
    chk("oor_frame_done", 32'(ok), 32'd1);
    repeat (5) @(negedge clk);
    chk("oor_no_draw", 32'(go_q.size() - base), 32'd0);
    chk("oor_fd",      32'(fd_cnt - fdb),       32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
